dlx_bus_ctrl: RTL and testbench

- Memory-bus access controller directly downstream of the DLX address-extension stage; consumes the 32-bit zero-extended address `AO` and runs one read or write bus transaction per request.
- Latches address and write data, drives a request/acknowledge handshake to external memory, returns read data, and aborts on a wait-state timeout.
- Sits between the DLX control FSM (request/done handshake) and the memory bus.

---
 rtl/dlx_bus_ctrl.sv | 135 +++++++++++++
 tb/tb_dlx_bus_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dlx_bus_ctrl.sv
// Memory-bus access controller for the DLX: accepts one read or write request at a time,
// runs a REQ/ACK handshake with external memory and aborts after TIMEOUT wait cycles.
module dlx_bus_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] AO,
   input  logic [31:0] DI,
   input  logic        REQ_RD,
   input  logic        REQ_WR,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic [31:0] BUS_ADDR,
   output logic [31:0] BUS_DOUT,
   input  logic [31:0] BUS_IN,
   output logic        BUS_RD,
   output logic        BUS_WR,
   input  logic        BUS_ACK
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FIN  = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       addr_reg, addr_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [31:0]       rdata_reg, rdata_next;
   logic              dir_rd_reg, dir_rd_next;

   // Visible outputs are flops loaded from the decoded next state, so strobes never glitch.
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic              bus_rd_reg, bus_rd_next;
   logic              bus_wr_reg, bus_wr_next;
   logic [31:0]       bus_dout_reg, bus_dout_next;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
         dir_rd_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         bus_rd_reg   <= 1'b0;
         bus_wr_reg   <= 1'b0;
         bus_dout_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         rdata_reg    <= rdata_next;
         dir_rd_reg   <= dir_rd_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         bus_rd_reg   <= bus_rd_next;
         bus_wr_reg   <= bus_wr_next;
         bus_dout_reg <= bus_dout_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      rdata_next  = rdata_reg;
      dir_rd_next = dir_rd_reg;
      case (state_reg)
         ST_IDLE: begin
            if (REQ_RD && REQ_WR) begin
               state_next = ST_FAIL;
            end else if (REQ_RD || REQ_WR) begin
               state_next  = ST_REQ;
               addr_next   = AO;
               wdata_next  = DI;
               dir_rd_next = REQ_RD;
               cnt_next    = '0;
            end
         end
         ST_REQ: begin
            // ACK wins over the timeout check in the final wait cycle.
            if (BUS_ACK) begin
               state_next = ST_FIN;
               if (dir_rd_reg) begin
                  rdata_next = BUS_IN;
               end
            end else if (cnt_reg == LAST_CNT) begin
               state_next = ST_FAIL;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         ST_FAIL: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_next     = (state_next == ST_REQ);
      done_next     = (state_next == ST_FIN) || (state_next == ST_FAIL);
      err_next      = (state_next == ST_FAIL);
      bus_rd_next   = busy_next && dir_rd_next;
      bus_wr_next   = busy_next && !dir_rd_next;
      bus_dout_next = bus_wr_next ? wdata_next : 32'd0;
   end

   assign BUSY     = busy_reg;
   assign DONE     = done_reg;
   assign ERR      = err_reg;
   assign RDATA    = rdata_reg;
   assign BUS_ADDR = addr_reg;
   assign BUS_DOUT = bus_dout_reg;
   assign BUS_RD   = bus_rd_reg;
   assign BUS_WR   = bus_wr_reg;

endmodule

// File: tb/tb_dlx_bus_ctrl.sv
// Directed bench for dlx_bus_ctrl: a table of complete transactions plus hand-written
// sequences for ignored requests, stray ACK and reset in the middle of a transaction.
module tb_dlx_bus_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] AO, DI, BUS_IN;
   logic        REQ_RD, REQ_WR, BUS_ACK;
   logic        BUSY, DONE, ERR, BUS_RD, BUS_WR;
   logic [31:0] RDATA, BUS_ADDR, BUS_DOUT;

   int tests  = 0;
   int failed = 0;
   logic [31:0] last_addr = 32'd0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] ao;
      logic [31:0] di;
      logic [31:0] bus_in;
      int          ack_at;      // strobe cycle (1-based) carrying ACK; 0 = never
      int          exp_strobes;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[7];

   dlx_bus_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .AO(AO), .DI(DI), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .BUS_ADDR(BUS_ADDR),
      .BUS_DOUT(BUS_DOUT), .BUS_IN(BUS_IN), .BUS_RD(BUS_RD), .BUS_WR(BUS_WR),
      .BUS_ACK(BUS_ACK)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   cyc;
      int   nstrobe;
      logic got_done;
      @(negedge CLK);
      check("idle_before_req", {30'd0, BUSY, DONE}, 32'd0);
      AO = v.ao; DI = v.di; BUS_IN = v.bus_in;
      REQ_RD = v.rd; REQ_WR = v.wr; BUS_ACK = 1'b0;
      if (v.rd ^ v.wr) last_addr = v.ao;
      @(posedge CLK);
      #1;
      REQ_RD = 1'b0; REQ_WR = 1'b0;
      AO = ~v.ao; DI = ~v.di;            // latched copies must be used from here on
      cyc = 0; nstrobe = 0; got_done = 1'b0;
      while (!got_done && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         if (BUS_RD || BUS_WR) begin
            nstrobe++;
            check("strobe_dir_rd", BUS_RD, v.rd);
            check("strobe_exclusive", BUS_RD & BUS_WR, 1'b0);
            check("busy_in_req", BUSY, 1'b1);
            check("bus_addr", BUS_ADDR, v.ao);
            check("bus_dout", BUS_DOUT, v.wr ? v.di : 32'd0);
            BUS_ACK = (nstrobe == v.ack_at);
         end else begin
            BUS_ACK = 1'b0;
         end
         if (DONE) begin
            got_done = 1'b1;
            check("done_latency", cyc, v.exp_strobes + 1);
            check("strobe_count", nstrobe, v.exp_strobes);
            check("err", ERR, v.exp_err);
            check("rdata", RDATA, v.exp_rdata);
            check("addr_held", BUS_ADDR, last_addr);
            check("busy_at_done", BUSY, 1'b0);
         end
      end
      BUS_ACK = 1'b0;
      check("done_seen", got_done, 1'b1);
      $display("[TB] txn %0d: rd=%0b wr=%0b addr=0x%08h strobes=%0d err=%0b rdata=0x%08h",
               idx, v.rd, v.wr, v.ao, nstrobe, ERR, RDATA);
   endtask

   initial begin
      int   ndone, nrd, nwr, nact;
      vec_t post;

      //           rd    wr    ao             di             bus_in         ack str err rdata
      vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'hDEAD_BEEF,  1,  1, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_00FF, 32'hA5A5_A5A5, 32'h1357_9BDF,  4,  4, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 32'h1111_1111,  0, 15, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'hCAFE_F00D, 15, 15, 1'b0, 32'hCAFE_F00D};
      vecs[4] = '{1'b1, 1'b1, 32'h0000_4000, 32'h5555_5555, 32'h2222_2222,  0,  0, 1'b1, 32'hCAFE_F00D};
      vecs[5] = '{1'b0, 1'b1, 32'h0000_5000, 32'h1234_5678, 32'h3333_3333,  2,  2, 1'b0, 32'hCAFE_F00D};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_6000, 32'h8765_4321, 32'h4444_4444,  0, 15, 1'b1, 32'hCAFE_F00D};

      RESET = 1'b1; AO = '0; DI = '0; BUS_IN = '0;
      REQ_RD = 1'b0; REQ_WR = 1'b0; BUS_ACK = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_ctrl", {27'd0, BUSY, DONE, ERR, BUS_RD, BUS_WR}, 32'd0);
      check("reset_rdata", RDATA, 32'd0);
      check("reset_addr", BUS_ADDR, 32'd0);
      check("reset_dout", BUS_DOUT, 32'd0);
      RESET = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Write request mid-read (REQ and FIN) must be ignored; exactly one DONE.
      @(negedge CLK);
      AO = 32'h0000_0400; REQ_RD = 1'b1; BUS_IN = 32'h0BAD_F00D;
      @(negedge CLK);
      REQ_RD = 1'b0;
      ndone = 0; nrd = 0; nwr = 0;
      for (int c = 1; c <= 8; c++) begin
         if (DONE) ndone++;
         if (BUS_RD) nrd++;
         if (BUS_WR) nwr++;
         REQ_WR  = (c == 2) || (c == 4);
         BUS_ACK = (c == 3);
         @(negedge CLK);
      end
      REQ_WR = 1'b0; BUS_ACK = 1'b0;
      check("ignored_wr_done_count", ndone, 1);
      check("ignored_wr_rd_cycles", nrd, 3);
      check("ignored_wr_no_wr", nwr, 0);
      check("ignored_wr_rdata", RDATA, 32'h0BAD_F00D);
      $display("[TB] txn mid-read REQ_WR: dones=%0d rd_cycles=%0d wr_cycles=%0d", ndone, nrd, nwr);

      // Stray ACK while idle.
      BUS_ACK = 1'b1; BUS_IN = 32'hFFFF_FFFF;
      nact = 0;
      repeat (3) begin
         @(negedge CLK);
         if (DONE || ERR || BUSY || BUS_RD || BUS_WR) nact++;
      end
      BUS_ACK = 1'b0;
      check("stray_ack_activity", nact, 0);
      check("stray_ack_rdata", RDATA, 32'h0BAD_F00D);
      $display("[TB] txn stray ACK: activity_cycles=%0d", nact);

      // Reset during the 5th REQ cycle of a read that never gets ACK.
      @(negedge CLK);
      AO = 32'h0000_0800; REQ_RD = 1'b1;
      @(negedge CLK);
      REQ_RD = 1'b0;
      repeat (4) @(negedge CLK);
      check("rst_strobe_before", BUS_RD, 1'b1);
      RESET = 1'b1;
      @(negedge CLK);
      check("rst_mid_ctrl", {27'd0, BUSY, DONE, ERR, BUS_RD, BUS_WR}, 32'd0);
      check("rst_mid_rdata", RDATA, 32'd0);
      check("rst_mid_addr", BUS_ADDR, 32'd0);
      check("rst_mid_dout", BUS_DOUT, 32'd0);
      RESET = 1'b0;
      nact = 0;
      repeat (4) begin
         @(negedge CLK);
         if (DONE || BUSY || BUS_RD) nact++;
      end
      check("rst_quiet_after", nact, 0);
      $display("[TB] txn reset mid-read: post_reset_activity=%0d", nact);
      last_addr = 32'd0;

      post = '{1'b1, 1'b0, 32'h0000_0900, 32'h0000_0000, 32'h600D_CAFE, 2, 2, 1'b0, 32'h600D_CAFE};
      run_vec(7, post);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
